// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   BIN_DIG   : instruction width in bits
//   MEM_SIZE  : instruction memory depth in words
//   RESET_PC  : program counter value loaded at reset
//   fetch_state_t : sequencer states (RUN, FULL, HALTED)
//   fetch_entry_t : one queued fetch result {pc, inst} at default widths
package inst_fetch_ctrl_pkg;

  localparam int BIN_DIG      = 32;
  localparam int MEM_SIZE     = 16;
  localparam int FETCH_ADDR_W = $clog2(MEM_SIZE);
  localparam int RESET_PC     = 0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FULL   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [BIN_DIG-1:0]      inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Two-entry in-order FIFO holding fetched instructions.
// Knows nothing about the program counter; it only stores entries.
//   clk, rst : clock, synchronous active-high reset
//   push     : write din (accepted when not full, or when popping too)
//   pop      : drop the head (ignored when empty)
//   flush    : empty the queue; overrides push/pop
//   din      : entry to write
//   head     : oldest entry (slot 0), registered
//   count    : number of valid entries, 0..2
module inst_queue
  import inst_fetch_ctrl_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     din,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t     slot0_reg;
  entry_t     slot1_reg;
  logic [1:0] count_reg;

  logic do_pop;
  logic do_push;

  assign do_pop  = pop && (count_reg != 2'd0);
  assign do_push = push && ((count_reg != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_reg <= '0;
      slot1_reg <= '0;
      count_reg <= 2'd0;
    end else if (flush) begin
      count_reg <= 2'd0;
    end else begin
      // Shift first; a simultaneous write into slot 0 below takes priority.
      if (do_pop) begin
        slot0_reg <= slot1_reg;
      end
      if (do_push) begin
        // New entry lands in the first slot that is free after the pop.
        if ((count_reg == 2'd0) || ((count_reg == 2'd1) && do_pop)) begin
          slot0_reg <= din;
        end else begin
          slot1_reg <= din;
        end
      end
      count_reg <= count_reg + 2'(do_push) - 2'(do_pop);
    end
  end

  assign head  = slot0_reg;
  assign count = count_reg;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch-side sequencer: owns the program counter, drives the word address
// to the instruction memory, captures the combinationally returned
// instruction into a 2-entry queue and presents the queue head to decode.
//   clk, rst       : clock, synchronous active-high reset
//   addr           : word address to instruction memory (= PC register)
//   curr_inst      : instruction at addr, returned combinationally
//   redirect_valid : load redirect_pc and flush the queue this cycle
//   redirect_pc    : redirect target
//   halt           : stop issuing fetches (queue still drains)
//   inst_valid     : queue head valid (registered)
//   inst, inst_pc  : queue head instruction and its PC (registered)
//   inst_ready     : decode accepts the head
module inst_fetch_ctrl #(
  parameter int BIN_DIG  = inst_fetch_ctrl_pkg::BIN_DIG,
  parameter int MEM_SIZE = inst_fetch_ctrl_pkg::MEM_SIZE,
  parameter int ADDR_W   = $clog2(MEM_SIZE),
  parameter int RESET_PC = inst_fetch_ctrl_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  addr,
  input  logic [BIN_DIG-1:0] curr_inst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               inst_valid,
  output logic [BIN_DIG-1:0] inst,
  output logic [ADDR_W-1:0]  inst_pc,
  input  logic               inst_ready
);
  import inst_fetch_ctrl_pkg::*;

  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_FULL   = FULL;
  localparam logic [1:0] ST_HALTED = HALTED;

  // Entry layout sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [BIN_DIG-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_inc;
  logic [1:0]        state_reg;
  logic [1:0]        state_next;

  entry_t     push_entry;
  entry_t     head;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       pop;
  logic       push;

  assign pop = (count != 2'd0) && inst_ready;

  // Fetching stops the very cycle halt is seen, and redirect cycles only
  // reload the PC; the new target is fetched on the following cycle.
  assign push = (state_reg != ST_HALTED) && !halt && !redirect_valid &&
                ((count != 2'd2) || pop);

  assign pc_inc = (pc_reg == ADDR_W'(MEM_SIZE - 1)) ? '0 : pc_reg + ADDR_W'(1);

  assign count_next = count + 2'(push) - 2'(pop);

  always_comb begin
    pc_next = pc_reg;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (push) begin
      pc_next = pc_inc;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (redirect_valid) begin
      state_next = ST_RUN;
    end else if (halt) begin
      state_next = ST_HALTED;
    end else begin
      case (state_reg)
        ST_RUN:    if (!pop && (count_next == 2'd2)) state_next = ST_FULL;
        ST_FULL:   if (pop) state_next = ST_RUN;
        ST_HALTED: state_next = ST_HALTED;
        default:   state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= ADDR_W'(RESET_PC);
      state_reg <= ST_RUN;
    end else begin
      pc_reg    <= pc_next;
      state_reg <= state_next;
    end
  end

  assign push_entry.pc   = pc_reg;
  assign push_entry.inst = curr_inst;

  inst_queue #(
    .entry_t (entry_t)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  assign addr       = pc_reg;
  assign inst_valid = (count != 2'd0);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Fetch-side sequencer that drives the instruction address into the `fetcher` instruction memory over `fetchToDecode` and hands instructions to decode. It holds the program counter and captures the combinationally returned `curr_inst` into a 2-entry instruction queue. Decode consumes the queue through a valid/ready handshake. The block also accepts PC redirects (branch/jump) and a halt request.

## Interface
- `BIN_DIG`, default from `defs` (32): instruction width.
- `MEM_SIZE`, default from `defs`: instruction memory depth in words.
- `ADDR_W`, default `$clog2(MEM_SIZE)`: PC/address width.
- `RESET_PC`, default 0: PC value loaded at reset.
- Timing: one clock, `clk`. Reset `rst` is synchronous and active-high.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  out  ADDR_W  word address to `fetcher` (the `fetchToDecode.addr` modport signal).
- `curr_inst`  in  BIN_DIG  instruction at `addr`, returned combinationally by `fetcher`.
- `redirect_valid`  in  1  load a new PC this cycle.
- `redirect_pc`  in  ADDR_W  target PC.
- `halt`  in  1  stop issuing new fetches.
- `inst_valid`  out  1  queue head is valid.
- `inst`  out  BIN_DIG  queue head instruction.
- `inst_pc`  out  ADDR_W  PC of the queue head.
- `inst_ready`  in  1  decode accepts the head.

## Operation
- `addr` = PC register, combinational.
- Push and pop rules:
  - Push: in RUN, when `count<2` or a pop occurs the same cycle, and no redirect, push {PC, `curr_inst`} and set PC ← PC+1.
  - PC wraps from MEM_SIZE-1 to 0.
  - Pop: when `inst_valid && inst_ready`.
  - Push and pop in the same cycle at count=2 or count=1: count unchanged, order preserved.
- FSM states are RUN, FULL and HALTED:
  - RUN → FULL when count reaches 2 with no pop.
  - FULL → RUN on any pop (a push is allowed that same cycle).
  - RUN or FULL → HALTED when `halt`=1. No push occurs in the cycle `halt` is sampled. The queue still drains.
  - HALTED → RUN only on `redirect_valid`. `halt` is ignored when `redirect_valid` is asserted the same cycle.
- Redirect:
  - The queue is flushed (count ← 0) and PC ← `redirect_pc`. No push that cycle.
  - A head handshake in the redirect cycle still counts as accepted; squashing it is decode's responsibility.
- Reset values: PC=RESET_PC, count=0, state=RUN, `inst_valid`=0, `inst`=0, `inst_pc`=0.
- Reset mid-operation discards queue contents and any pending redirect.

## Timing
- Fetch-to-valid latency: `curr_inst` is sampled at the clock edge, so an instruction fetched in cycle N appears on `inst`/`inst_valid` in cycle N+1.
- First valid after reset release: reset low in cycle 0 → fetch RESET_PC in cycle 0 → `inst_valid` in cycle 1.
- Redirect latency: `redirect_valid` in cycle N → `addr`=`redirect_pc` in N+1 → instruction valid in N+2. `inst_valid`=0 in N+1.
- Steady-state throughput with `inst_ready`=1: one instruction per cycle.
- Register outputs: `inst`, `inst_pc` and `inst_valid` come from queue registers, with no combinational path from `inst_ready`.
- The only combinational output is `addr`.

## Structure
- `defs` package:
  - `fetch_state_t` enum {RUN, FULL, HALTED}.
  - `fetch_entry_t` struct {pc, inst}.
  - `RESET_PC`; existing `BIN_DIG` and `MEM_SIZE`.
- Sub-module `inst_queue`: 2-entry FIFO of `fetch_entry_t` with push, pop, flush and count. It has no knowledge of the PC.
- Top level holds the PC register and the FSM, and drives `fetchToDecode` from the fetch-side modport counterpart.

## Test plan
- Reset release with memory[0..3]=11,22,33,44 and `inst_ready`=1 → `inst` = 11,22,33,44 on cycles 1..4, `inst_pc` = 0..3.
- Hold `inst_ready`=0 for 5 cycles → count saturates at 2, PC stops at 2, the head stays at 11. On ready=1 the stream continues 22,33,44 with no loss or duplication.
- `redirect_valid`=1, `redirect_pc`=8 at cycle 3 with the queue holding 2 entries → `inst_valid`=0 in cycle 4, `inst`=memory[8] with `inst_pc`=8 in cycle 5.
- PC=MEM_SIZE-1 with ready=1 → next `inst_pc`=0 (wrap).
- `halt`=1 at cycle 2 → no further pushes, queued entries drain, then `inst_valid`=0 indefinitely. A redirect to 4 resumes with `inst_pc`=4 two cycles later.
- `rst`=1 asserted mid-stream with count=2 → next cycle all outputs are at reset values and `addr`=RESET_PC.
